// File: rtl/sprite_collision_unit.sv
// rtl/sprite_collision_unit.sv - per-frame pairwise sprite collision detector and report
//
// Purpose: ANDs every pair of gfx layers during the visible area, accumulates
// the overlaps over one frame and publishes a frame-stable report on the rising
// edge of vsync. The first rise after reset only primes the unit, because the
// frame in progress at reset release is partial.
//
// Optional feature macro: COLL_STICKY_EN (adds ack; report ORs across frames
// until acknowledged). Undefined: each publication overwrites the report.
//
// Ports:
//   clk, reset          clock, asynchronous active-high reset
//   vsync               rising edge marks the frame boundary
//   display_on          visible-area qualifier
//   hpos, vpos          current pixel position (9 bits each)
//   gfx[NUM_OBJ]        per-object pixel-on bits
//   ack                 (COLL_STICKY_EN only) clears the published report
//   coll[NUM_PAIRS]     published pair flags, pairs (i<j) enumerated i then j
//   obj_hit[NUM_OBJ]    published per-object involvement
//   hit_x, hit_y        position of the first colliding pixel
//   hit_valid           hit_x/hit_y meaningful
//   hit_count           colliding pixels in the frame, saturating at 255
//   frame_done          one-cycle pulse on each publication
module sprite_collision_unit #(
    parameter int  NUM_OBJ   = 4,
    localparam int NUM_PAIRS = NUM_OBJ * (NUM_OBJ - 1) / 2
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 vsync,
    input  logic                 display_on,
    input  logic [8:0]           hpos,
    input  logic [8:0]           vpos,
    input  logic [NUM_OBJ-1:0]   gfx,
`ifdef COLL_STICKY_EN
    input  logic                 ack,
`endif
    output logic [NUM_PAIRS-1:0] coll,
    output logic [NUM_OBJ-1:0]   obj_hit,
    output logic [8:0]           hit_x,
    output logic [8:0]           hit_y,
    output logic                 hit_valid,
    output logic [7:0]           hit_count,
    output logic                 frame_done
);

    // Mask of the pair bits that involve object 'obj'.
    function automatic logic [NUM_PAIRS-1:0] obj_mask(input int obj);
        logic [NUM_PAIRS-1:0] m;
        int p;
        m = '0;
        p = 0;
        for (int i = 0; i < NUM_OBJ; i++) begin
            for (int j = i + 1; j < NUM_OBJ; j++) begin
                if (i == obj || j == obj) m = m | (NUM_PAIRS'(1) << p);
                p++;
            end
        end
        return m;
    endfunction

    logic                 r_vsync_d;
    logic                 r_primed;
    logic [NUM_PAIRS-1:0] r_acc_pairs;
    logic [7:0]           r_acc_cnt;
    logic [8:0]           r_acc_x;
    logic [8:0]           r_acc_y;
    logic                 r_acc_v;

    logic [NUM_PAIRS-1:0] r_coll;
    logic [NUM_OBJ-1:0]   r_obj_hit;
    logic [8:0]           r_hit_x;
    logic [8:0]           r_hit_y;
    logic                 r_hit_valid;
    logic [7:0]           r_hit_count;
    logic                 r_frame_done;

    logic                 w_rise;
    logic [NUM_PAIRS-1:0] w_hits;
    logic [NUM_OBJ-1:0]   w_acc_obj;
    logic                 w_clr;
    logic                 w_sticky;

    assign w_rise = vsync & ~r_vsync_d;

    // Pair index for (i,j): pairs of all earlier rows, then offset within row i.
    for (genvar gi = 0; gi < NUM_OBJ; gi++) begin : g_row
        for (genvar gj = gi + 1; gj < NUM_OBJ; gj++) begin : g_col
            localparam int P = gi * (2 * NUM_OBJ - gi - 1) / 2 + (gj - gi - 1);
            assign w_hits[P] = gfx[gi] & gfx[gj] & display_on;
        end
    end

    for (genvar go = 0; go < NUM_OBJ; go++) begin : g_obj
        localparam logic [NUM_PAIRS-1:0] M = obj_mask(go);
        assign w_acc_obj[go] = |(r_acc_pairs & M);
    end

`ifdef COLL_STICKY_EN
    assign w_clr    = ack;
    assign w_sticky = 1'b1;
`else
    assign w_clr    = 1'b0;
    assign w_sticky = 1'b0;
`endif

    // w_keep_*: report after an optional ack clear. w_base_*: what a
    // publication merges into (the kept report when sticky, empty otherwise).
    logic [NUM_PAIRS-1:0] w_keep_coll, w_base_coll;
    logic [NUM_OBJ-1:0]   w_keep_obj,  w_base_obj;
    logic [8:0]           w_keep_x,    w_keep_y;
    logic                 w_keep_v,    w_base_v;
    logic [7:0]           w_keep_cnt,  w_base_cnt;
    logic [8:0]           w_cnt_sum;
    logic [7:0]           w_cnt_pub;

    assign w_keep_coll = w_clr ? '0    : r_coll;
    assign w_keep_obj  = w_clr ? '0    : r_obj_hit;
    assign w_keep_x    = w_clr ? 9'd0  : r_hit_x;
    assign w_keep_y    = w_clr ? 9'd0  : r_hit_y;
    assign w_keep_v    = w_clr ? 1'b0  : r_hit_valid;
    assign w_keep_cnt  = w_clr ? 8'd0  : r_hit_count;

    assign w_base_coll = w_sticky ? w_keep_coll : '0;
    assign w_base_obj  = w_sticky ? w_keep_obj  : '0;
    assign w_base_v    = w_sticky ? w_keep_v    : 1'b0;
    assign w_base_cnt  = w_sticky ? w_keep_cnt  : 8'd0;

    assign w_cnt_sum   = {1'b0, w_base_cnt} + {1'b0, r_acc_cnt};
    assign w_cnt_pub   = w_cnt_sum[8] ? 8'hFF : w_cnt_sum[7:0];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_vsync_d    <= 1'b0;
            r_primed     <= 1'b0;
            r_acc_pairs  <= '0;
            r_acc_cnt    <= 8'd0;
            r_acc_x      <= 9'd0;
            r_acc_y      <= 9'd0;
            r_acc_v      <= 1'b0;
            r_coll       <= '0;
            r_obj_hit    <= '0;
            r_hit_x      <= 9'd0;
            r_hit_y      <= 9'd0;
            r_hit_valid  <= 1'b0;
            r_hit_count  <= 8'd0;
            r_frame_done <= 1'b0;
        end else begin
            r_vsync_d    <= vsync;
            r_frame_done <= 1'b0;

            r_coll       <= w_keep_coll;
            r_obj_hit    <= w_keep_obj;
            r_hit_x      <= w_keep_x;
            r_hit_y      <= w_keep_y;
            r_hit_valid  <= w_keep_v;
            r_hit_count  <= w_keep_cnt;

            if (w_rise) begin
                if (r_primed) begin
                    r_coll       <= w_base_coll | r_acc_pairs;
                    r_obj_hit    <= w_base_obj | w_acc_obj;
                    r_hit_count  <= w_cnt_pub;
                    r_frame_done <= 1'b1;
                    // First-hit position survives across sticky frames.
                    if (!w_base_v) begin
                        r_hit_x     <= r_acc_x;
                        r_hit_y     <= r_acc_y;
                        r_hit_valid <= r_acc_v;
                    end
                end
                r_primed    <= 1'b1;
                // Hits on the rise cycle itself belong to no frame.
                r_acc_pairs <= '0;
                r_acc_cnt   <= 8'd0;
                r_acc_x     <= 9'd0;
                r_acc_y     <= 9'd0;
                r_acc_v     <= 1'b0;
            end else begin
                r_acc_pairs <= r_acc_pairs | w_hits;
                if (|w_hits) begin
                    if (r_acc_cnt != 8'hFF) r_acc_cnt <= r_acc_cnt + 8'd1;
                    if (!r_acc_v) begin
                        r_acc_x <= hpos;
                        r_acc_y <= vpos;
                        r_acc_v <= 1'b1;
                    end
                end
            end
        end
    end

    assign coll       = r_coll;
    assign obj_hit    = r_obj_hit;
    assign hit_x      = r_hit_x;
    assign hit_y      = r_hit_y;
    assign hit_valid  = r_hit_valid;
    assign hit_count  = r_hit_count;
    assign frame_done = r_frame_done;

endmodule

// File: tb/tb_sprite_collision_unit.sv
// tb/tb_sprite_collision_unit.sv - directed self-checking bench for sprite_collision_unit
module tb_sprite_collision_unit;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       vsync = 1'b0;
    logic       display_on = 1'b0;
    logic [8:0] hpos = 9'd0;
    logic [8:0] vpos = 9'd0;
    logic [3:0] gfx = 4'd0;
    logic       ack = 1'b0;
    logic [5:0] coll;
    logic [3:0] obj_hit;
    logic [8:0] hit_x;
    logic [8:0] hit_y;
    logic       hit_valid;
    logic [7:0] hit_count;
    logic       frame_done;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    sprite_collision_unit #(.NUM_OBJ(4)) dut (
        .clk        (clk),
        .reset      (reset),
        .vsync      (vsync),
        .display_on (display_on),
        .hpos       (hpos),
        .vpos       (vpos),
        .gfx        (gfx),
`ifdef COLL_STICKY_EN
        .ack        (ack),
`endif
        .coll       (coll),
        .obj_hit    (obj_hit),
        .hit_x      (hit_x),
        .hit_y      (hit_y),
        .hit_valid  (hit_valid),
        .hit_count  (hit_count),
        .frame_done (frame_done)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pix(input logic [3:0] g, input int x, input int y, input logic de);
        gfx = g; hpos = 9'(x); vpos = 9'(y); display_on = de;
        tick();
        gfx = 4'd0; display_on = 1'b0;
    endtask

    // vsync high for 'hold' cycles; rise_g/ack_r are applied on the rise cycle only.
    // Returns frame_done right after the rise and the count of later pulses.
    task automatic vpulse(input int hold, input logic [3:0] rise_g, input logic ack_r,
                          output logic fd, output int extra);
        extra = 0;
        vsync = 1'b1; gfx = rise_g; display_on = |rise_g; ack = ack_r;
        tick();
        fd = frame_done;
        gfx = 4'd0; display_on = 1'b0; ack = 1'b0;
        for (int k = 1; k < hold; k++) begin
            tick();
            if (frame_done) extra++;
        end
        vsync = 1'b0;
        tick();
        if (frame_done) extra++;
    endtask

    task automatic check_report(input string tag, input logic [5:0] c, input logic [3:0] o,
                                input int x, input int y, input logic v, input int cnt);
        check({tag, ".coll"},      32'(coll),      32'(c));
        check({tag, ".obj_hit"},   32'(obj_hit),   32'(o));
        check({tag, ".hit_x"},     32'(hit_x),     32'(x));
        check({tag, ".hit_y"},     32'(hit_y),     32'(y));
        check({tag, ".hit_valid"}, 32'(hit_valid), 32'(v));
        check({tag, ".hit_count"}, 32'(hit_count), 32'(cnt));
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic fd;
        int   extra;

        repeat (3) tick();
        check_report("reset", 6'd0, 4'd0, 0, 0, 1'b0, 0);
        check("reset.frame_done", 32'(frame_done), 32'd0);
        reset = 1'b0;
        tick();

        // Partial frame with an overlap: the first rise only primes.
        pix(4'b0011, 3, 3, 1'b1);
        vpulse(4, 4'd0, 1'b0, fd, extra);
        check("unprimed.frame_done", 32'(fd), 32'd0);
        check_report("unprimed", 6'd0, 4'd0, 0, 0, 1'b0, 0);

        // Empty frame publishes an empty report; long vsync gives one pulse only.
        repeat (5) tick();
        vpulse(40, 4'd0, 1'b0, fd, extra);
        check("empty.frame_done", 32'(fd), 32'd1);
        check("empty.single_pulse", 32'(extra), 32'd0);
        check_report("empty", 6'd0, 4'd0, 0, 0, 1'b0, 0);

`ifdef COLL_STICKY_EN
        // Frame A: pair0 at (11,12). Frame B: pair5 at (13,14). Report accumulates.
        pix(4'b0011, 11, 12, 1'b1);
        vpulse(3, 4'd0, 1'b0, fd, extra);
        check("stA.frame_done", 32'(fd), 32'd1);
        pix(4'b1100, 13, 14, 1'b1);
        vpulse(3, 4'd0, 1'b0, fd, extra);
        check("stB.frame_done", 32'(fd), 32'd1);
        check_report("stB", 6'b100001, 4'b1111, 11, 12, 1'b1, 2);
        // Frame C empty, ack coincident with its rise.
        repeat (4) tick();
        vpulse(3, 4'd0, 1'b1, fd, extra);
        check("stC.frame_done", 32'(fd), 32'd1);
        check_report("stC", 6'd0, 4'd0, 0, 0, 1'b0, 0);
        // Standalone ack clears a live report.
        pix(4'b0101, 21, 22, 1'b1);
        vpulse(3, 4'd0, 1'b0, fd, extra);
        check_report("stD", 6'b000010, 4'b0101, 21, 22, 1'b1, 1);
        ack = 1'b1; tick(); ack = 1'b0;
        check_report("stD.ack", 6'd0, 4'd0, 0, 0, 1'b0, 0);
`else
        // Pair (0,1) for 3 pixels starting at (40,50).
        pix(4'b0011, 40, 50, 1'b1);
        pix(4'b0011, 41, 50, 1'b1);
        pix(4'b0011, 42, 50, 1'b1);
        vpulse(3, 4'd0, 1'b0, fd, extra);
        check("f1.frame_done", 32'(fd), 32'd1);
        check_report("f1", 6'b000001, 4'b0011, 40, 50, 1'b1, 3);
        repeat (20) tick();
        check("f1.hold.coll", 32'(coll), 32'h01);

        // Three objects on one pixel: three pairs, one count; previous report overwritten.
        pix(4'b1101, 10, 20, 1'b1);
        vpulse(3, 4'd0, 1'b0, fd, extra);
        check_report("f2", 6'b100110, 4'b1101, 10, 20, 1'b1, 1);

        // Blanked overlap first, then 300 visible pixels; hits on the rise discarded.
        for (int k = 0; k < 20; k++) pix(4'b0110, 5 + k, 5, 1'b0);
        for (int k = 0; k < 300; k++) pix(4'b0110, 100 + k, 7, 1'b1);
        vpulse(3, 4'b0011, 1'b0, fd, extra);
        check_report("f3", 6'b001000, 4'b0110, 100, 7, 1'b1, 255);
        repeat (5) tick();
        vpulse(3, 4'd0, 1'b0, fd, extra);
        check_report("f4", 6'd0, 4'd0, 0, 0, 1'b0, 0);

        // Reset mid-frame clears a live report and re-arms priming.
        pix(4'b1001, 3, 4, 1'b1);
        vpulse(3, 4'd0, 1'b0, fd, extra);
        check_report("f5", 6'b000100, 4'b1001, 3, 4, 1'b1, 1);
        pix(4'b0011, 60, 61, 1'b1);
        reset = 1'b1; tick();
        check_report("midreset", 6'd0, 4'd0, 0, 0, 1'b0, 0);
        reset = 1'b0; tick();
        pix(4'b0011, 62, 61, 1'b1);
        vpulse(3, 4'd0, 1'b0, fd, extra);
        check("postreset.frame_done", 32'(fd), 32'd0);
        check_report("postreset", 6'd0, 4'd0, 0, 0, 1'b0, 0);
        pix(4'b1010, 7, 8, 1'b1);
        vpulse(3, 4'd0, 1'b0, fd, extra);
        check("f6.frame_done", 32'(fd), 32'd1);
        check_report("f6", 6'b010000, 4'b1010, 7, 8, 1'b1, 1);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
